pulse_frontend: RTL

- Parametrised per-channel pulse conditioning stage between the raw detector inputs and the correlator core (`main`).
- Next generation of the fixed single-edge delay/compare front end.
- Per channel:
  - synchroniser
  - run-time polarity select
  - run-time edge-mode select (off / rising / falling / both)
  - dead-time suppression of re-triggers
  - saturating event counter, readable through a select port
- Outputs are single-cycle event pulses in the `clk` domain.

---
 rtl/pulse_frontend_pkg.sv | 17 +
 rtl/pulse_channel.sv | 102 ++++++++++
 rtl/pulse_frontend.sv | 87 ++++++++
 3 files changed

// File: rtl/pulse_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_frontend_pkg
// Description : Shared edge-mode encoding for the pulse conditioning front end.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_frontend_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t EDGE_OFF  = 2'b00;
    localparam edge_mode_t EDGE_RISE = 2'b01;
    localparam edge_mode_t EDGE_FALL = 2'b10;
    localparam edge_mode_t EDGE_BOTH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pulse_channel.sv
`default_nettype none
// ============================================================================
// Module      : pulse_channel
// Description : One detector channel: sync, polarity, edge select, dead-time
//               hold-off and saturating event counter with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_channel
    import pulse_frontend_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEADTIME_WIDTH = 8,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      primed,
    input  logic                      pulse_in,
    input  logic                      invert,
    input  logic [1:0]                edge_mode,
    input  logic [DEADTIME_WIDTH-1:0] deadtime,
    input  logic                      count_clear,
    output logic                      pulse_out,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      count_ovf
);

    localparam logic [DEADTIME_WIDTH-1:0] c_dead_one  = {{(DEADTIME_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]    c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0]    r_sync;
    logic                      r_hist;
    logic [DEADTIME_WIDTH-1:0] r_dead;
    logic [COUNT_WIDTH-1:0]    r_count;
    logic                      r_ovf;
    logic                      r_pulse;

    logic w_a;
    logic w_b;
    logic w_rise;
    logic w_fall;
    logic w_hit;
    logic w_emit;

    // Both samples use the present invert value, so flipping polarity alone
    // can never look like an edge.
    assign w_a    = r_sync[SYNC_STAGES-1] ^ invert;
    assign w_b    = r_hist ^ invert;
    assign w_rise = w_a & ~w_b;
    assign w_fall = ~w_a & w_b;

    always_comb begin
        w_hit = 1'b0;
        case (edge_mode)
            EDGE_RISE: w_hit = w_rise;
            EDGE_FALL: w_hit = w_fall;
            EDGE_BOTH: w_hit = w_rise | w_fall;
            default:   w_hit = 1'b0;
        endcase
    end

    assign w_emit = w_hit & primed & (r_dead == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_dead  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pulse_in};
            r_hist  <= r_sync[SYNC_STAGES-1];
            r_pulse <= w_emit;

            if (w_emit) begin
                r_dead <= deadtime;
            end else if (r_dead != '0) begin
                r_dead <= r_dead - c_dead_one;
            end

            // Clear outranks a coincident event; the strobe itself still fires.
            if (count_clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_emit) begin
                if (&r_count) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + c_count_one;
                end
            end
        end
    end

    assign pulse_out = r_pulse;
    assign count     = r_count;
    assign count_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/pulse_frontend.sv
`default_nettype none
// ============================================================================
// Module      : pulse_frontend
// Description : Multi-channel pulse conditioning stage ahead of the correlator;
//               start-up priming mask and registered counter read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_frontend
    import pulse_frontend_pkg::*;
#(
    parameter int NUM_INPUTS     = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int DEADTIME_WIDTH = 8,
    parameter int COUNT_WIDTH    = 16,
    parameter int SEL_WIDTH      = $clog2(NUM_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_INPUTS-1:0]     pulse_in,
    input  logic [NUM_INPUTS-1:0]     invert,
    input  logic [2*NUM_INPUTS-1:0]   edge_mode,
    input  logic [DEADTIME_WIDTH-1:0] deadtime,
    input  logic                      count_clear,
    input  logic [SEL_WIDTH-1:0]      count_sel,
    output logic [NUM_INPUTS-1:0]     pulse_out,
    output logic [COUNT_WIDTH-1:0]    count_out,
    output logic [NUM_INPUTS-1:0]     count_ovf
);

    localparam int                   c_prime_w    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_prime_w-1:0] c_prime_done = c_prime_w'(SYNC_STAGES + 1);
    localparam logic [c_prime_w-1:0] c_prime_one  = {{(c_prime_w-1){1'b0}}, 1'b1};
    localparam int                   c_sel_slots  = 2 ** SEL_WIDTH;

    logic [c_prime_w-1:0]   r_prime_cnt;
    logic                   w_primed;
    logic [COUNT_WIDTH-1:0] w_count [c_sel_slots];

    // Hold edge detection off until the sync chain and history flop carry
    // post-reset samples, so a level already active at release is ignored.
    assign w_primed = (r_prime_cnt == c_prime_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime_cnt <= '0;
        end else if (!w_primed) begin
            r_prime_cnt <= r_prime_cnt + c_prime_one;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
            pulse_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEADTIME_WIDTH (DEADTIME_WIDTH),
                .COUNT_WIDTH    (COUNT_WIDTH)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .primed      (w_primed),
                .pulse_in    (pulse_in[gi]),
                .invert      (invert[gi]),
                .edge_mode   (edge_mode[2*gi +: 2]),
                .deadtime    (deadtime),
                .count_clear (count_clear),
                .pulse_out   (pulse_out[gi]),
                .count       (w_count[gi]),
                .count_ovf   (count_ovf[gi])
            );
        end

        // Unpopulated select codes read as zero.
        for (genvar gp = NUM_INPUTS; gp < c_sel_slots; gp++) begin : g_pad
            assign w_count[gp] = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
        end else begin
            count_out <= w_count[count_sel];
        end
    end

endmodule
`default_nettype wire
